// File: rtl/can_bit_destuff.sv
// ---------------------------------------------------------------------------
// can_bit_destuff
//
// Receive-path bit de-stuffing stage for a CAN / CAN FD receiver. Takes one
// sampled bus bit per bit time from the bit timing logic and forwards only
// the data bits to the bit stream processor. Stuff bits are removed, stuff
// rule violations are flagged, and the dynamic stuff-bit count is kept for
// the FD stuff count field check.
//
// Optional feature macro: CAN_FD_FIXED_STUFF_EN
//   Defined   : fixed_stuff=1 selects the FD fixed-stuff region (a stuff bit
//               before the first data bit and after every 4 data bits).
//   Undefined : fixed_stuff is ignored, classical dynamic stuffing only.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   sample_point   in   one-cycle pulse, once per bit
//   sampled_bit    in   bus value, valid while sample_point=1
//   destuff_en     in   dynamic stuffing active
//   fixed_stuff    in   FD fixed-stuff region
//   clear          in   synchronous clear (frame start, error frame, idle)
//   bit_valid      out  pulse: bit_out carries a data bit
//   bit_out        out  de-stuffed data bit
//   stuff_drop     out  pulse: a correct stuff bit was removed
//   stuff_err      out  pulse: stuff rule violated
//   stuff_cnt_gray out  dynamic stuff count mod 8, Gray coded
//   stuff_cnt_par  out  even parity over stuff_cnt_gray
// ---------------------------------------------------------------------------
module can_bit_destuff (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       sampled_bit,
    input  logic       destuff_en,
    input  logic       fixed_stuff,
    input  logic       clear,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       stuff_drop,
    output logic       stuff_err,
    output logic [2:0] stuff_cnt_gray,
    output logic       stuff_cnt_par
);

    logic       last_bit,  last_bit_nxt;
    logic [2:0] run_cnt,   run_cnt_nxt;
    logic [2:0] stuff_cnt, stuff_cnt_nxt;
    logic       err_hold,  err_hold_nxt;
    logic       bit_valid_nxt, bit_out_nxt, stuff_drop_nxt, stuff_err_nxt;

`ifdef CAN_FD_FIXED_STUFF_EN
    logic [2:0] fix_cnt,   fix_cnt_nxt;
    logic       fix_first, fix_first_nxt;
`else
    logic unused_fixed_stuff;
    assign unused_fixed_stuff = fixed_stuff;
`endif

    // Next-state and output decode for one sampled bit. Once a stuff error
    // has been seen the stage goes quiet until the next clear.
    always_comb begin
        last_bit_nxt   = last_bit;
        run_cnt_nxt    = run_cnt;
        stuff_cnt_nxt  = stuff_cnt;
        err_hold_nxt   = err_hold;
        bit_valid_nxt  = 1'b0;
        bit_out_nxt    = bit_out;
        stuff_drop_nxt = 1'b0;
        stuff_err_nxt  = 1'b0;
`ifdef CAN_FD_FIXED_STUFF_EN
        fix_cnt_nxt    = fix_cnt;
        fix_first_nxt  = fix_first;
`endif

        if (clear) begin
            last_bit_nxt  = 1'b1;
            run_cnt_nxt   = 3'd0;
            stuff_cnt_nxt = 3'd0;
            err_hold_nxt  = 1'b0;
`ifdef CAN_FD_FIXED_STUFF_EN
            fix_cnt_nxt   = 3'd0;
            fix_first_nxt = 1'b1;
`endif
        end else if (sample_point && !err_hold) begin
`ifdef CAN_FD_FIXED_STUFF_EN
            if (fixed_stuff) begin
                // Fixed stuff bit leads the region and follows every 4 data
                // bits; it must be the complement of the previous bit.
                run_cnt_nxt = 3'd0;
                if (fix_first || fix_cnt == 3'd4) begin
                    if (sampled_bit != last_bit) begin
                        stuff_drop_nxt = 1'b1;
                        fix_first_nxt  = 1'b0;
                        fix_cnt_nxt    = 3'd0;
                        last_bit_nxt   = sampled_bit;
                    end else begin
                        stuff_err_nxt  = 1'b1;
                        err_hold_nxt   = 1'b1;
                    end
                end else begin
                    bit_valid_nxt = 1'b1;
                    bit_out_nxt   = sampled_bit;
                    fix_cnt_nxt   = fix_cnt + 3'd1;
                    last_bit_nxt  = sampled_bit;
                end
            end else
`endif
            if (!destuff_en) begin
                // Outside the stuffed region: pass through and restart the
                // run so the first stuffed bit always begins a fresh run.
                bit_valid_nxt = 1'b1;
                bit_out_nxt   = sampled_bit;
                run_cnt_nxt   = 3'd0;
                last_bit_nxt  = sampled_bit;
            end else if (run_cnt == 3'd5) begin
                if (sampled_bit != last_bit) begin
                    // The stuff bit itself opens the next run.
                    stuff_drop_nxt = 1'b1;
                    run_cnt_nxt    = 3'd1;
                    stuff_cnt_nxt  = stuff_cnt + 3'd1;
                    last_bit_nxt   = sampled_bit;
                end else begin
                    stuff_err_nxt  = 1'b1;
                    err_hold_nxt   = 1'b1;
                end
            end else begin
                bit_valid_nxt = 1'b1;
                bit_out_nxt   = sampled_bit;
                last_bit_nxt  = sampled_bit;
                run_cnt_nxt   = (sampled_bit == last_bit && run_cnt != 3'd0)
                                ? run_cnt + 3'd1 : 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_bit   <= 1'b1;
            run_cnt    <= 3'd0;
            stuff_cnt  <= 3'd0;
            err_hold   <= 1'b0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b1;
            stuff_drop <= 1'b0;
            stuff_err  <= 1'b0;
`ifdef CAN_FD_FIXED_STUFF_EN
            fix_cnt    <= 3'd0;
            fix_first  <= 1'b1;
`endif
        end else begin
            last_bit   <= last_bit_nxt;
            run_cnt    <= run_cnt_nxt;
            stuff_cnt  <= stuff_cnt_nxt;
            err_hold   <= err_hold_nxt;
            bit_valid  <= bit_valid_nxt;
            bit_out    <= bit_out_nxt;
            stuff_drop <= stuff_drop_nxt;
            stuff_err  <= stuff_err_nxt;
`ifdef CAN_FD_FIXED_STUFF_EN
            fix_cnt    <= fix_cnt_nxt;
            fix_first  <= fix_first_nxt;
`endif
        end
    end

    assign stuff_cnt_gray = stuff_cnt ^ (stuff_cnt >> 1);
    assign stuff_cnt_par  = ^stuff_cnt_gray;

endmodule

// File: tb/tb_can_bit_destuff.sv
// ---------------------------------------------------------------------------
// tb_can_bit_destuff
//
// Self-checking bench for can_bit_destuff. A stream-level model (history of
// accepted bits, plain stuff-event count) predicts every output; a negedge
// compare process checks the DUT each cycle, and literal expectations from
// hand-worked bit sequences pin the model.
// ---------------------------------------------------------------------------
module tb_can_bit_destuff;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_point;
    logic       sampled_bit;
    logic       destuff_en;
    logic       fixed_stuff;
    logic       clear;
    logic       bit_valid;
    logic       bit_out;
    logic       stuff_drop;
    logic       stuff_err;
    logic [2:0] stuff_cnt_gray;
    logic       stuff_cnt_par;

    int checks = 0;
    int errors = 0;

    can_bit_destuff dut (
        .clk            (clk),
        .rst            (rst),
        .sample_point   (sample_point),
        .sampled_bit    (sampled_bit),
        .destuff_en     (destuff_en),
        .fixed_stuff    (fixed_stuff),
        .clear          (clear),
        .bit_valid      (bit_valid),
        .bit_out        (bit_out),
        .stuff_drop     (stuff_drop),
        .stuff_err      (stuff_err),
        .stuff_cnt_gray (stuff_cnt_gray),
        .stuff_cnt_par  (stuff_cnt_par)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle, and the ones the next edge
    // will bring.
    logic       exp_valid = 1'b0, exp_drop = 1'b0, exp_err = 1'b0, exp_bit = 1'b1;
    logic [2:0] exp_gray = 3'd0;
    logic       exp_par  = 1'b0;
    logic       nxt_valid, nxt_drop, nxt_err, nxt_bit;
    logic [2:0] nxt_gray;
    logic       nxt_par;

    // Model state: recent accepted bits in the current run window.
    logic m_q[$];
    logic m_last  = 1'b1;
    int   m_stuff = 0;
    logic m_hold  = 1'b0;
    int   m_fix_pos = 0;

    bit cmp_on = 1'b0;
    int cnt_valid = 0, cnt_drop = 0, cnt_err = 0;

    task automatic checkOutput(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [2:0] gray_of(input int n);
        case (n % 8)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b110;
            5: return 3'b111;
            6: return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last    = 1'b1;
        m_stuff   = 0;
        m_hold    = 1'b0;
        m_fix_pos = 0;
    endtask

    task automatic model_step(input logic b, input logic en, input logic fx,
                              input logic sp, input logic clr);
        logic fixed_mode;
        logic run_full;
        fixed_mode = 1'b0;
`ifdef CAN_FD_FIXED_STUFF_EN
        fixed_mode = fx;
`endif
        nxt_valid = 1'b0;
        nxt_drop  = 1'b0;
        nxt_err   = 1'b0;
        nxt_bit   = exp_bit;
        if (clr) begin
            model_reset();
        end else if (sp && !m_hold) begin
            if (fixed_mode) begin
                m_q.delete();
                if (m_fix_pos % 5 == 0) begin
                    if (b == !m_last) nxt_drop = 1'b1;
                    else begin nxt_err = 1'b1; m_hold = 1'b1; end
                end else begin
                    nxt_valid = 1'b1;
                    nxt_bit   = b;
                end
                if (!m_hold) begin
                    m_last = b;
                    m_fix_pos++;
                end
            end else if (!en) begin
                nxt_valid = 1'b1;
                nxt_bit   = b;
                m_q.delete();
                m_last = b;
            end else begin
                run_full = (m_q.size() == 5);
                for (int i = 0; i < m_q.size(); i++)
                    if (m_q[i] != m_q[m_q.size()-1]) run_full = 1'b0;
                if (run_full) begin
                    if (b != m_q[m_q.size()-1]) begin
                        nxt_drop = 1'b1;
                        m_stuff++;
                    end else begin
                        nxt_err = 1'b1;
                        m_hold  = 1'b1;
                    end
                end else begin
                    nxt_valid = 1'b1;
                    nxt_bit   = b;
                end
                if (!m_hold) begin
                    m_q.push_back(b);
                    if (m_q.size() > 5) void'(m_q.pop_front());
                    m_last = b;
                end
            end
        end
        nxt_gray = gray_of(m_stuff);
        nxt_par  = ^nxt_gray;
    endtask

    // Drives one bit time (two clocks). Entered and left at posedge+1.
    task automatic applyStimulus(input logic b, input logic en, input logic fx,
                                 input logic sp, input logic clr);
        sample_point = sp;
        sampled_bit  = b;
        destuff_en   = en;
        fixed_stuff  = fx;
        clear        = clr;
        model_step(b, en, fx, sp, clr);
        @(posedge clk); #1;
        exp_valid = nxt_valid;
        exp_drop  = nxt_drop;
        exp_err   = nxt_err;
        exp_bit   = nxt_bit;
        exp_gray  = nxt_gray;
        exp_par   = nxt_par;
        sample_point = 1'b0;
        clear        = 1'b0;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        exp_drop  = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n,
                             input logic en, input logic fx);
        for (int i = 0; i < n; i++) applyStimulus(bits[i], en, fx, 1'b1, 1'b0);
    endtask

    task automatic do_clear();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("bit_valid", bit_valid, exp_valid);
            checkOutput("stuff_drop", stuff_drop, exp_drop);
            checkOutput("stuff_err", stuff_err, exp_err);
            checkOutput("stuff_cnt_gray", stuff_cnt_gray, exp_gray);
            checkOutput("stuff_cnt_par", stuff_cnt_par, exp_par);
            if (exp_valid) checkOutput("bit_out", bit_out, exp_bit);
            if (bit_valid)  cnt_valid++;
            if (stuff_drop) cnt_drop++;
            if (stuff_err)  cnt_err++;
        end
    end

    initial begin
        int v0, d0, e0;
        rst = 1'b0;
        sample_point = 1'b0;
        sampled_bit  = 1'b1;
        destuff_en   = 1'b0;
        fixed_stuff  = 1'b0;
        clear        = 1'b0;
        cmp_on       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_bit_out", bit_out, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // 0,0,0,0,0,1,0 : five data, stuff dropped, one data
        $display("[TB] basic stuff drop");
        v0 = cnt_valid; d0 = cnt_drop; e0 = cnt_err;
        send_bits(32'b0100000, 7, 1'b1, 1'b0);
        checkOutput("t1_valid_cnt", cnt_valid - v0, 6);
        checkOutput("t1_drop_cnt", cnt_drop - d0, 1);
        checkOutput("t1_gray", stuff_cnt_gray, 3'b001);
        checkOutput("t1_par", stuff_cnt_par, 1);

        // Six ones: stuff error, then silence until clear
        $display("[TB] stuff error and hold");
        do_clear();
        v0 = cnt_valid; d0 = cnt_drop; e0 = cnt_err;
        send_bits(32'b010111111, 9, 1'b1, 1'b0);
        checkOutput("t2_valid_cnt", cnt_valid - v0, 5);
        checkOutput("t2_err_cnt", cnt_err - e0, 1);
        checkOutput("t2_drop_cnt", cnt_drop - d0, 0);

        // Eleven stuff events: count wraps to 3
        $display("[TB] stuff count wrap");
        do_clear();
        v0 = cnt_valid; d0 = cnt_drop;
        for (int k = 0; k < 11; k++) send_bits(32'b100000, 6, 1'b1, 1'b0);
        checkOutput("t3_drop_cnt", cnt_drop - d0, 11);
        checkOutput("t3_valid_cnt", cnt_valid - v0, 55);
        checkOutput("t3_gray", stuff_cnt_gray, 3'b010);
        checkOutput("t3_par", stuff_cnt_par, 1);

        // Clear coincident with sample_point mid-run
        $display("[TB] clear wins over sample_point");
        do_clear();
        v0 = cnt_valid; d0 = cnt_drop; e0 = cnt_err;
        send_bits(32'b0000, 4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_bits(32'b00000, 5, 1'b1, 1'b0);
        checkOutput("t4_valid_cnt", cnt_valid - v0, 9);
        checkOutput("t4_drop_cnt", cnt_drop - d0, 0);
        checkOutput("t4_err_cnt", cnt_err - e0, 0);
        checkOutput("t4_gray", stuff_cnt_gray, 3'b000);

        // Pass-through: long run is not stuffed, then dynamic run restarts
        $display("[TB] pass-through region");
        do_clear();
        v0 = cnt_valid; d0 = cnt_drop; e0 = cnt_err;
        send_bits(32'b0000000, 7, 1'b0, 1'b0);
        send_bits(32'b100000, 6, 1'b1, 1'b0);
        checkOutput("t5_valid_cnt", cnt_valid - v0, 12);
        checkOutput("t5_drop_cnt", cnt_drop - d0, 1);
        checkOutput("t5_err_cnt", cnt_err - e0, 0);

`ifdef CAN_FD_FIXED_STUFF_EN
        $display("[TB] fixed stuff region");
        do_clear();
        v0 = cnt_valid; d0 = cnt_drop; e0 = cnt_err;
        send_bits(32'b011010, 6, 1'b1, 1'b1);
        checkOutput("t6_valid_cnt", cnt_valid - v0, 4);
        checkOutput("t6_drop_cnt", cnt_drop - d0, 2);
        checkOutput("t6_gray", stuff_cnt_gray, 3'b000);
        do_clear();
        e0 = cnt_err;
        send_bits(32'b111010, 6, 1'b1, 1'b1);
        checkOutput("t6_err_cnt", cnt_err - e0, 1);
`endif

        // Asynchronous reset mid-frame
        $display("[TB] async reset mid-frame");
        do_clear();
        for (int k = 0; k < 2; k++) send_bits(32'b100000, 6, 1'b1, 1'b0);
        checkOutput("t7_gray_pre", stuff_cnt_gray, 3'b011);
        cmp_on = 1'b0;
        sample_point = 1'b1;
        sampled_bit  = 1'b0;
        @(posedge clk); #1;
        checkOutput("t7_valid_pre", bit_valid, 1);
        sample_point = 1'b0;
        #1 rst = 1'b0;
        #1;
        checkOutput("t7_rst_valid", bit_valid, 0);
        checkOutput("t7_rst_gray", stuff_cnt_gray, 0);
        checkOutput("t7_rst_par", stuff_cnt_par, 0);
        checkOutput("t7_rst_bit_out", bit_out, 1);
        model_reset();
        exp_valid = 1'b0; exp_drop = 1'b0; exp_err = 1'b0;
        exp_bit = 1'b1; exp_gray = 3'd0; exp_par = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        cmp_on = 1'b1;
        @(posedge clk); #1;
        checkOutput("t7_gray_post", stuff_cnt_gray, 0);
        v0 = cnt_valid; d0 = cnt_drop;
        send_bits(32'b100000, 6, 1'b1, 1'b0);
        checkOutput("t7_valid_post", cnt_valid - v0, 5);
        checkOutput("t7_drop_post", cnt_drop - d0, 1);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_bit_destuff.md
# can_bit_destuff

Receive-path bit de-stuffing stage for the CAN/CAN FD receiver. It sits directly downstream of the bit timing logic: it consumes `sample_point` / `sampled_bit` once per bit time and hands the bit stream processor de-stuffed data bits. It also reports stuff errors and keeps the dynamic stuff-bit count that the FD stuff count field is checked against.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `sample_point`  in  1  one-cycle pulse from bit timing, once per bit.
- `sampled_bit`  in  1  bus value valid while `sample_point`=1.
- `destuff_en`  in  1  dynamic stuffing active (SOF through end of data field); sampled only on `sample_point`.
- `fixed_stuff`  in  1  FD fixed-stuff region (stuff count + CRC field); see Configuration.
- `clear`  in  1  synchronous clear (frame start, error/overload frame, bus idle).
- `bit_valid`  out  1  pulse: `bit_out` is a data bit.
- `bit_out`  out  1  de-stuffed data bit.
- `stuff_drop`  out  1  pulse: a correct stuff bit was removed.
- `stuff_err`  out  1  pulse: stuff rule violated.
- `stuff_cnt_gray`  out  3  dynamic stuff count mod 8, Gray coded.
- `stuff_cnt_par`  out  1  even parity over `stuff_cnt_gray`.

## Operation
- State: `last_bit`, run counter `run_cnt`[2:0], `stuff_cnt`[2:0], fixed counter `fix_cnt`[2:0], `fix_first`, `err_hold`.
- `clear` or reset: `run_cnt`=0, `stuff_cnt`=0, `fix_cnt`=0, `fix_first`=1, `err_hold`=0, `last_bit`=1.
- A `sample_point` with `err_hold`=1 produces no output pulses. `err_hold` is left only by `clear`.
- `destuff_en`=0 and not fixed: the bit passes through (`bit_valid`=1), `run_cnt`=0, `last_bit` updated.
- Dynamic mode (`destuff_en`=1, `fixed_stuff`=0):
  - `run_cnt`=5 and bit != `last_bit`: stuff bit. Assert `stuff_drop`, no `bit_valid`, `run_cnt`=1, `stuff_cnt`+1 (wraps 7→0).
  - `run_cnt`=5 and bit == `last_bit`: assert `stuff_err`, set `err_hold`.
  - Otherwise: data bit. `run_cnt` = (bit == `last_bit` and `run_cnt`≠0) ? `run_cnt`+1 : 1.
  - `last_bit` is updated on every accepted bit, stuff bits included.
- Fixed mode: described in Configuration. `stuff_cnt` is frozen in fixed mode.
- `stuff_cnt_gray` = `stuff_cnt` ^ (`stuff_cnt`>>1), combinational from the register. `stuff_cnt_par` = XOR of the three Gray bits.

## Timing
- All pulse outputs and `bit_out` are registered. They assert exactly 1 clk after the `sample_point` cycle and last 1 clk.
- At most one of `bit_valid`/`stuff_drop`/`stuff_err` asserts per bit.
- Reset values: `bit_valid`=0, `bit_out`=1, `stuff_drop`=0, `stuff_err`=0, `stuff_cnt_gray`=0, `stuff_cnt_par`=0.
- `clear` coincident with `sample_point`: `clear` wins, the bit is discarded, no pulse.
- `stuff_cnt` updates in the same cycle as `stuff_drop`.
- `destuff_en` / `fixed_stuff` changes take effect at the next `sample_point`.
- Minimum `sample_point` spacing is 2 clk.

## Configuration
- Macro: `CAN_FD_FIXED_STUFF_EN`.
- Defined: `fixed_stuff`=1 overrides `destuff_en`.
  - First bit with `fix_first`=1 is a fixed stuff bit; it must equal ~`last_bit`. Then `fix_first`=0, `fix_cnt`=0.
  - Each following bit is data: `bit_valid`, `fix_cnt`+1.
  - When `fix_cnt`=4, the next bit is a fixed stuff bit: it must equal ~`last_bit`, then `fix_cnt`=0.
  - Correct fixed stuff bit: `stuff_drop`. Wrong value: `stuff_err` + `err_hold`.
  - Fixed stuff bits do not increment `stuff_cnt`. `run_cnt` is held at 0.
- Undefined: the `fixed_stuff` input is ignored (unconnected logic) and the fixed counters are not built. Behaviour is classical CAN dynamic stuffing only.

## Test plan
- Bits 0,0,0,0,0,1,0 with `destuff_en`=1 → five `bit_valid` (0), `stuff_drop` on 6th bit, `bit_valid` with 0 on 7th; `stuff_cnt_gray`=001, `stuff_cnt_par`=1.
- Six consecutive 1s with `destuff_en`=1 → five `bit_valid`, `stuff_err` on 6th; following bits produce no pulses until `clear`.
- 11 stuff events (runs of 5 zeros, each followed by a 1) → `stuff_cnt`=3 (wrap), `stuff_cnt_gray`=010, `stuff_cnt_par`=1.
- `CAN_FD_FIXED_STUFF_EN`, `last_bit`=1, `fixed_stuff`=1, bits 0,1,0,1,1,0 → `stuff_drop`, 4×`bit_valid` (1,0,1,1), `stuff_drop`; bit 1 in the 6th position instead → `stuff_err`.
- `clear` asserted in the same cycle as `sample_point`, mid-run with `run_cnt`=4 → no pulse; the next five equal bits yield five `bit_valid` and no stuff action.
- `rst` asserted mid-frame → all outputs at reset values immediately (asynchronous), `stuff_cnt`=0 after release.
